dds_wb_master: RTL and testbench

Wishbone initiator for the DDS register block: turns a simple valid/ready command stream into single Wishbone classic transfers on the `simple_dds` register bus, one outstanding at a time. After reset it autonomously polls the READY register until the slave reports ready, and only then accepts commands. It sits between a host/sequencer and the `simple_dds` slave port, in the `wb_clk_i` domain.

---
 rtl/dds_wb_pkg.sv | 31 +++
 rtl/dds_wbm_timer.sv | 45 ++++
 rtl/dds_wb_master.sv | 232 +++++++++++++++++++++++
 tb/tb_dds_wb_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_wb_pkg.sv
// Shared definitions for the DDS register bus initiator.
//   - Register address map of the simple_dds slave.
//   - Reset values of the slave registers, shared with the slave and the bench.
//   - Initiator FSM state encoding.
package dds_wb_pkg;

  // Register address map
  localparam int unsigned ADDR_READY       = 0;
  localparam int unsigned ADDR_ENABLE      = 1;
  localparam int unsigned ADDR_DDS_SRC     = 2;
  localparam int unsigned ADDR_TUNING_WORD = 3;
  localparam int unsigned ADDR_GAIN_WORD   = 4;
  localparam int unsigned ADDR_OFFSET_WORD = 5;

  // Slave register reset values
  localparam logic [31:0] RST_ENABLE      = 32'h0000_0000;
  localparam logic [31:0] RST_DDS_SRC     = 32'h0000_0000;
  localparam logic [31:0] RST_TUNING_WORD = 32'h0000_0000;
  localparam logic [31:0] RST_GAIN_WORD   = 32'h0000_8000;
  localparam logic [31:0] RST_OFFSET_WORD = 32'h0000_0000;

  // Initiator FSM states
  typedef enum logic [2:0] {
    ST_POLL     = 3'd0,
    ST_POLL_GAP = 3'd1,
    ST_IDLE     = 3'd2,
    ST_BUS      = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

endpackage

// File: rtl/dds_wbm_timer.sv
// Loadable down-counter shared by the READY-poll gap wait and the strobe
// timeout.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load load_i into the counter (wins over clear_i)
//   clear_i       : force the counter to 0 (idle, never expires)
//   load_i        : count value; expired_o fires load_i cycles after start_i
//   expired_o     : high during the last counted cycle (count == 1)
module dds_wbm_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] load_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = load_i;
    end else if (clear_i) begin
      count_d = '0;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count value 1 marks the final cycle, so a load of N gives exactly N
  // cycles before the consuming edge; 0 is the idle value.
  assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/dds_wb_master.sv
// Wishbone classic initiator for the simple_dds register block.
// After reset it polls READY (address 0) until bit 0 reads 1, then accepts
// commands one at a time and returns one response per command.
//
// Handshakes: a command transfers on a clock edge where cmd_valid_i and
// cmd_ready_o are both 1; a response transfers on an edge where rsp_valid_o
// and rsp_ready_i are both 1. Valid is held with stable payload until it
// transfers. Only one of command / bus transfer / response is in flight.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wb_dat_o/addr_o/we_o/stb_o   Wishbone request (all registered)
//   wb_dat_i, wb_ack_i           Wishbone reply (ack ignored while stb low)
//   cmd_valid_i/ready_o/we_i/addr_i/data_i   command stream
//   rsp_valid_o/ready_i/rdata_o/err_o        response stream
//   init_done_o                  READY poll finished, sticky until reset
//   dbg_state_o                  current FSM state
//
// Build option: DDS_WBM_TIMEOUT_EN enables the strobe timeout. When it is not
// defined the block waits for ack indefinitely and rsp_err_o is constant 0.
module dds_wb_master
  import dds_wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int POLL_GAP_CYCLES = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  init_done_o,
  output state_e                dbg_state_o
);

`ifdef DDS_WBM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(POLL_GAP_CYCLES + 1);
  localparam int TMR_W = (TO_W > GAP_W) ? TO_W : GAP_W;
  localparam logic [TMR_W-1:0]      GAP_LOAD = TMR_W'(POLL_GAP_CYCLES);
  localparam logic [TMR_W-1:0]      TO_LOAD  = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] READY_A  = ADDR_WIDTH'(ADDR_READY);

  state_e                state_q,     state_d;
  logic                  stb_q,       stb_d;
  logic                  we_q,        we_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] dat_q,       dat_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
  logic                  err_q,       err_d;
  logic                  init_done_q, init_done_d;

  logic             tmr_start;
  logic             tmr_clear;
  logic [TMR_W-1:0] tmr_load;
  logic             tmr_expired;
  logic             tmo;

  // The one timer serves both waits: while the strobe is high it counts the
  // timeout, while it is low (POLL_GAP) it counts the gap.
  dds_wbm_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .start_i   (tmr_start),
    .clear_i   (tmr_clear),
    .load_i    (tmr_load),
    .expired_o (tmr_expired)
  );

  assign tmo = TMO_EN & stb_q & tmr_expired;

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    tmr_start   = 1'b0;
    tmr_clear   = 1'b0;
    tmr_load    = TO_LOAD;

    unique case (state_q)
      ST_POLL: begin
        if (!stb_q) begin
          // Only reached straight after reset: raise the first poll.
          stb_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = READY_A;
          tmr_start = TMO_EN;
        end else if (wb_ack_i) begin
          stb_d     = 1'b0;
          tmr_clear = 1'b1;
          if (wb_dat_i[0]) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
            cmd_ready_d = 1'b1;
          end else begin
            state_d   = ST_POLL_GAP;
            tmr_start = 1'b1;
            tmr_load  = GAP_LOAD;
          end
        end else if (tmo) begin
          // Unanswered poll: retry after the normal gap, no error.
          stb_d     = 1'b0;
          state_d   = ST_POLL_GAP;
          tmr_start = 1'b1;
          tmr_load  = GAP_LOAD;
        end
      end

      ST_POLL_GAP: begin
        if (tmr_expired) begin
          state_d   = ST_POLL;
          stb_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = READY_A;
          tmr_start = TMO_EN;
        end
      end

      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          state_d     = ST_BUS;
          stb_d       = 1'b1;
          we_d        = cmd_we_i;
          addr_d      = cmd_addr_i;
          dat_d       = cmd_data_i;
          tmr_start   = TMO_EN;
        end
      end

      ST_BUS: begin
        // Ack is checked first so it wins over a same-edge timeout.
        if (stb_q && wb_ack_i) begin
          stb_d       = 1'b0;
          tmr_clear   = 1'b1;
          rdata_d     = we_q ? '0 : wb_dat_i;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (tmo) begin
          stb_d       = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_POLL;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_POLL;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end

  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = addr_q;
  assign wb_dat_o    = dat_q;
  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = TMO_EN ? err_q : 1'b0;
  assign init_done_o = init_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dds_wb_master.sv
// Directed bench for dds_wb_master with a behavioural simple_dds slave that
// acks one cycle after sampling the strobe and reports READY=1 from its third
// poll onwards.
module tb_dds_wb_master;
  import dds_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [31:0] wb_dat_o, wb_dat_i, rsp_rdata;
  logic [15:0] wb_addr_o, cmd_addr;
  logic        wb_we_o, wb_stb_o, wb_ack_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err, init_done;
  state_e      dbg_state;

  dds_wb_master dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wb_dat_o    (wb_dat_o),
    .wb_addr_o   (wb_addr_o),
    .wb_we_o     (wb_we_o),
    .wb_stb_o    (wb_stb_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .init_done_o (init_done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- slave model ----------------
  logic        no_ack = 1'b0;
  logic [31:0] sregs [8];
  int          poll_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= '0;
      poll_cnt <= 0;
      sregs[0] <= '0;
      sregs[1] <= RST_ENABLE;
      sregs[2] <= RST_DDS_SRC;
      sregs[3] <= RST_TUNING_WORD;
      sregs[4] <= RST_GAIN_WORD;
      sregs[5] <= RST_OFFSET_WORD;
      sregs[6] <= '0;
      sregs[7] <= '0;
    end else begin
      wb_ack_i <= 1'b0;
      if (wb_stb_o && !wb_ack_i && !no_ack) begin
        wb_ack_i <= 1'b1;
        if (wb_we_o) begin
          sregs[wb_addr_o[2:0]] <= wb_dat_o;
          wb_dat_i <= '0;
        end else if (wb_addr_o == 16'd0) begin
          wb_dat_i <= (poll_cnt >= 2) ? 32'd1 : 32'd0;
          poll_cnt <= poll_cnt + 1;
        end else begin
          wb_dat_i <= sregs[wb_addr_o[2:0]];
        end
      end
    end
  end

  // ---------------- bus monitor (samples 2 time units after each edge) ----
  int          rise_cnt = 0, high_run = 0, low_run = 0, last_high = 0, unstable = 0;
  int          poll_gaps[$];
  logic        prev_stb = 1'b0, mon_we = 1'b0;
  logic [15:0] mon_addr = '0;
  logic [31:0] mon_dat = '0;

  always begin
    @(posedge clk);
    #2;
    if (wb_stb_o) begin
      if (!prev_stb) begin
        rise_cnt++;
        if (wb_addr_o == 16'd0 && !wb_we_o) poll_gaps.push_back(low_run);
        mon_we = wb_we_o; mon_addr = wb_addr_o; mon_dat = wb_dat_o;
        high_run = 1;
      end else begin
        if (wb_we_o !== mon_we || wb_addr_o !== mon_addr || wb_dat_o !== mon_dat) unstable++;
        high_run++;
      end
      low_run = 0;
    end else begin
      if (prev_stb) last_high = high_run;
      low_run++;
    end
    prev_stb = wb_stb_o;
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Call at a negedge. Returns the response and the number of edges from the
  // handshake edge to the edge where the response is first consumable.
  task automatic run_cmd(input logic we, input logic [15:0] addr, input logic [31:0] data,
                         input bit consume, output logic [31:0] rdata, output logic err,
                         output int lat);
    int n;
    cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_in_time", 64'(n < 200), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (consume) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic wait_init(output int early_ready);
    int n;
    n = 0;
    early_ready = 0;
    while (init_done !== 1'b1 && n < 400) begin
      if (cmd_ready === 1'b1) early_ready++;
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd;
  logic        er;
  int          lat, early, r0, hs_cnt, bad_valid, bad_rdata, rdy_seen, stb_seen, n;

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_bus_outputs", 64'({wb_dat_o, wb_addr_o, wb_we_o, wb_stb_o}), 64'd0);
    chk("rst_rsp_outputs", 64'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_POLL));
    @(negedge clk);

    // Release with a command already waiting: it must not be taken before init
    poll_gaps.delete();
    r0 = rise_cnt;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'd5; cmd_data = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    wait_init(early);
    chk("init_done", 64'(init_done), 64'd1);
    chk("init_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("init_no_early_ready", 64'(early), 64'd0);
    chk("init_poll_count", 64'(poll_gaps.size()), 64'd3);
    chk("init_all_rises_polls", 64'(rise_cnt - r0), 64'd3);
    chk("init_gap1", 64'((poll_gaps.size() > 1) ? poll_gaps[1] : -1), 64'd8);
    chk("init_gap2", 64'((poll_gaps.size() > 2) ? poll_gaps[2] : -1), 64'd8);
    @(negedge clk);
    chk("init_cmd_not_taken", 64'(cmd_ready), 64'd1);

    // Write 0xFF to OFFSET_WORD
    r0 = rise_cnt;
    run_cmd(1'b1, 16'd5, 32'h0000_00FF, 1'b1, rd, er, lat);
    chk("wr_latency", 64'(lat), 64'd3);
    chk("wr_rdata", 64'(rd), 64'd0);
    chk("wr_err", 64'(er), 64'd0);
    chk("wr_one_strobe", 64'(rise_cnt - r0), 64'd1);
    chk("wr_strobe_attrs", 64'({mon_we, mon_addr, mon_dat}), {15'd0, 1'b1, 16'd5, 32'h0000_00FF});
    chk("wr_strobe_len", 64'(last_high), 64'd2);

    // Read it back, then GAIN reset value, then write/read GAIN
    run_cmd(1'b0, 16'd5, 32'h0, 1'b1, rd, er, lat);
    chk("rd5_rdata", 64'(rd), 64'h0000_00FF);
    chk("rd5_err", 64'(er), 64'd0);
    chk("rd5_strobe_we", 64'(mon_we), 64'd0);
    run_cmd(1'b0, 16'd4, 32'h0, 1'b1, rd, er, lat);
    chk("rd_gain_reset", 64'(rd), 64'h0000_8000);
    run_cmd(1'b1, 16'd4, 32'h1234_5678, 1'b1, rd, er, lat);
    chk("wr_gain_rdata", 64'(rd), 64'd0);
    run_cmd(1'b0, 16'd3, 32'hFFFF_FFFF, 1'b1, rd, er, lat);
    chk("rd_tuning_reset", 64'(rd), 64'd0);

    // Back-to-back throughput with rsp_ready tied high
    r0 = rise_cnt;
    cmd_we = 1'b1; cmd_addr = 16'd1; cmd_data = 32'd1;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready === 1'b1) hs_cnt++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    chk("b2b_handshakes_40cyc", 64'(hs_cnt), 64'd10);
    chk("b2b_strobes", 64'(rise_cnt - r0), 64'd10);

    // Response back-pressure for 10 cycles
    run_cmd(1'b0, 16'd4, 32'h0, 1'b0, rd, er, lat);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'd2; cmd_data = 32'h5;
    bad_valid = 0; bad_rdata = 0; rdy_seen = 0; stb_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1) bad_valid++;
      if (rsp_rdata !== rd) bad_rdata++;
      if (cmd_ready !== 1'b0) rdy_seen++;
      if (wb_stb_o !== 1'b0) stb_seen++;
    end
    cmd_valid = 1'b0;
    chk("hold_rdata_value", 64'(rd), 64'h1234_5678);
    chk("hold_valid_stable", 64'(bad_valid), 64'd0);
    chk("hold_rdata_stable", 64'(bad_rdata), 64'd0);
    chk("hold_no_cmd_ready", 64'(rdy_seen), 64'd0);
    chk("hold_no_strobe", 64'(stb_seen), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold_released_ready", 64'(cmd_ready), 64'd1);
    chk("hold_released_valid", 64'(rsp_valid), 64'd0);

`ifdef DDS_WBM_TIMEOUT_EN
    // Slave never acks: timeout after 64 strobe cycles
    no_ack = 1'b1;
    run_cmd(1'b0, 16'd2, 32'h0, 1'b1, rd, er, lat);
    no_ack = 1'b0;
    chk("tmo_strobe_len", 64'(last_high), 64'd64);
    chk("tmo_err", 64'(er), 64'd1);
    chk("tmo_rdata", 64'(rd), 64'd0);
    run_cmd(1'b0, 16'd5, 32'h0, 1'b1, rd, er, lat);
    chk("tmo_next_rdata", 64'(rd), 64'h0000_00FF);
    chk("tmo_next_err", 64'(er), 64'd0);
`endif

    chk("strobe_payload_stable", 64'(unstable), 64'd0);

    // Reset while a transfer is on the bus
    no_ack = 1'b1;
    cmd_we = 1'b1; cmd_addr = 16'd3; cmd_data = 32'hA5A5_0001; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_bus_strobe_high", 64'(wb_stb_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_outputs", 64'({wb_dat_o, wb_addr_o, wb_we_o, wb_stb_o}), 64'd0);
    chk("mid_rst_rsp_outputs", 64'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done}), 64'd0);
    @(negedge clk);
    no_ack = 1'b0;
    poll_gaps.delete();
    rst_n = 1'b1;
    chk("restart_state", 64'(dbg_state), 64'(ST_POLL));
    @(negedge clk);
    chk("restart_poll_strobe", 64'({wb_stb_o, wb_we_o, wb_addr_o}), {47'd0, 1'b1, 1'b0, 16'd0});
    wait_init(early);
    chk("restart_init_done", 64'(init_done), 64'd1);
    chk("restart_poll_count", 64'(poll_gaps.size()), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
